// File: rtl/tt_load_drain_ctrl_if.sv
// Drain/load-return/VRF-write signal bundle for tt_load_drain_ctrl.
// Signal names are seen from the drain controller: i_* are driven by the master side, o_* by the slave.
interface tt_load_drain_ctrl_if #(
    parameter int LQ_DEPTH   = 8,
    parameter int DATA_WIDTH = 512
) ();
    localparam int LQW = $clog2(LQ_DEPTH);

    logic                  i_drain_req;
    logic [LQW-1:0]        i_drain_ref_count;
    logic [LQW-1:0]        i_drain_lqid_start;
    logic                  o_draining;
    logic                  i_lq_wr_valid;
    logic [LQW-1:0]        i_lq_wr_lqid;
    logic [4:0]            i_lq_wr_vd;
    logic [DATA_WIDTH-1:0] i_lq_wr_data;
    logic                  o_vrf_wr_valid;
    logic                  i_vrf_wr_ready;
    logic [4:0]            o_vrf_wr_vd;
    logic [LQW-1:0]        o_vrf_wr_elem_idx;
    logic [DATA_WIDTH-1:0] o_vrf_wr_data;
    logic                  o_lq_commit;
    logic [LQW-1:0]        o_dest_lqid;
    logic                  o_err_overwrite;

    modport master (
        output i_drain_req, i_drain_ref_count, i_drain_lqid_start,
        output i_lq_wr_valid, i_lq_wr_lqid, i_lq_wr_vd, i_lq_wr_data,
        output i_vrf_wr_ready,
        input  o_draining, o_vrf_wr_valid, o_vrf_wr_vd, o_vrf_wr_elem_idx,
        input  o_vrf_wr_data, o_lq_commit, o_dest_lqid, o_err_overwrite
    );

    modport slave (
        input  i_drain_req, i_drain_ref_count, i_drain_lqid_start,
        input  i_lq_wr_valid, i_lq_wr_lqid, i_lq_wr_vd, i_lq_wr_data,
        input  i_vrf_wr_ready,
        output o_draining, o_vrf_wr_valid, o_vrf_wr_vd, o_vrf_wr_elem_idx,
        output o_vrf_wr_data, o_lq_commit, o_dest_lqid, o_err_overwrite
    );
endinterface

// File: rtl/tt_load_drain_ctrl.sv
// Load-queue data buffer and in-order drain engine towards the VRF write port.
// Optional TT_LQ_DRAIN_BYPASS_EN: forward a same-cycle load return for the head entry straight to the VRF port.
module tt_load_drain_ctrl #(
    parameter int LQ_DEPTH   = 8,
    parameter int DATA_WIDTH = 512
) (
    input logic                clk,
    input logic                reset_n,
    tt_load_drain_ctrl_if.slave lq_if
);
    localparam int LQW  = $clog2(LQ_DEPTH);
    localparam int CNTW = LQW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [LQW-1:0]        ptr_q, ptr_d;
    logic [LQW-1:0]        idx_q, idx_d;
    logic [CNTW-1:0]       remaining_q, remaining_d;
    logic                  err_q, err_d;
    logic [LQ_DEPTH-1:0]   valid_q, valid_d;
    logic [4:0]            vd_q   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [LQ_DEPTH];

    logic                  draining_s;
    logic                  wr_en_s;
    logic                  wr_ovw_s;
    logic                  bypass_s;
    logic                  vrf_valid_s;
    logic                  fire_s;
    logic [4:0]            vrf_vd_s;
    logic [DATA_WIDTH-1:0] vrf_data_s;

    assign draining_s = (state_q == ST_DRAIN);
    // Writes to an already-valid entry are dropped and flagged.
    assign wr_en_s    = lq_if.i_lq_wr_valid & ~valid_q[lq_if.i_lq_wr_lqid];
    assign wr_ovw_s   = lq_if.i_lq_wr_valid &  valid_q[lq_if.i_lq_wr_lqid];

`ifdef TT_LQ_DRAIN_BYPASS_EN
    assign bypass_s = draining_s & ~valid_q[ptr_q] & lq_if.i_lq_wr_valid &
                      (lq_if.i_lq_wr_lqid == ptr_q);
`else
    assign bypass_s = 1'b0;
`endif

    // VRF port source select: head entry from storage, or the forwarded load return.
    always_comb begin
        vrf_valid_s = draining_s & (valid_q[ptr_q] | bypass_s);
        if (bypass_s) begin
            vrf_vd_s   = lq_if.i_lq_wr_vd;
            vrf_data_s = lq_if.i_lq_wr_data;
        end else begin
            vrf_vd_s   = vd_q[ptr_q];
            vrf_data_s = data_q[ptr_q];
        end
    end

    assign fire_s = vrf_valid_s & lq_if.i_vrf_wr_ready;

    // Next-state for the drain FSM, entry valid bits and sticky error.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        err_d       = err_q | wr_ovw_s;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            // Clear wins so a forwarded entry that fires never becomes valid.
            valid_d[i] = (valid_q[i] | (wr_en_s && (lq_if.i_lq_wr_lqid == LQW'(i)))) &
                         ~(fire_s && (ptr_q == LQW'(i)));
        end
        case (state_q)
            ST_IDLE: begin
                if (lq_if.i_drain_req) begin
                    ptr_d   = lq_if.i_drain_lqid_start;
                    idx_d   = {LQW{1'b0}};
                    state_d = ST_DRAIN;
                    if (lq_if.i_drain_ref_count == {LQW{1'b0}}) begin
                        remaining_d = CNTW'(LQ_DEPTH);
                    end else begin
                        remaining_d = {1'b0, lq_if.i_drain_ref_count};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (fire_s) begin
                    ptr_d       = ptr_q + LQW'(1);
                    idx_d       = idx_q + LQW'(1);
                    remaining_d = remaining_q - CNTW'(1);
                    if (remaining_q == CNTW'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {LQW{1'b0}};
            idx_q       <= {LQW{1'b0}};
            remaining_q <= {CNTW{1'b0}};
            err_q       <= 1'b0;
            valid_q     <= {LQ_DEPTH{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
        end
    end

    // Entry payload storage; qualified by valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            vd_q[lq_if.i_lq_wr_lqid]   <= lq_if.i_lq_wr_vd;
            data_q[lq_if.i_lq_wr_lqid] <= lq_if.i_lq_wr_data;
        end
    end

    assign lq_if.o_draining        = draining_s;
    assign lq_if.o_vrf_wr_valid    = vrf_valid_s;
    assign lq_if.o_vrf_wr_vd       = vrf_vd_s;
    assign lq_if.o_vrf_wr_elem_idx = idx_q;
    assign lq_if.o_vrf_wr_data     = vrf_data_s;
    assign lq_if.o_lq_commit       = fire_s;
    assign lq_if.o_dest_lqid       = ptr_q;
    assign lq_if.o_err_overwrite   = err_q;
endmodule
